prog_sequence_generator: RTL

Parametrised, programmable successor to the fixed 3-bit/8-entry sequence generator. Pattern memory of DEPTH words of DATA_W bits is written through a config port. Playback runs in one-shot, loop or ping-pong mode with a programmable length and pass count. Output is a registered valid/ready stream that feeds downstream output/register stages in place of the gated-clock output register.

---
 rtl/prog_sequence_generator.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_sequence_generator.sv
// Programmable pattern sequencer: a DEPTH x DATA_W pattern RAM played back in one-shot, loop or
// ping-pong order as a registered valid/ready stream with per-pass out_last marking.
module prog_sequence_generator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned REP_W  = 8,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W-1:0] seq_len,
  input  logic [1:0]        mode,
  input  logic [REP_W-1:0]  passes,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] M_ONESHOT  = 2'b00;
  localparam logic [1:0] M_LOOP     = 2'b01;
  localparam logic [1:0] M_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUN      = 2'b01,
    S_STOPPING = 2'b10
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              up_q, up_d;
  logic [REP_W-1:0]  pass_q, pass_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [REP_W-1:0]  passes_q, passes_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer;
  logic              start_go;
  logic              final_beat;
  logic [ADDR_W-1:0] len_cap;
  logic [ADDR_W-1:0] idx_step;
  logic              up_step;
  logic              last_step;

  // Pattern RAM: no reset; a same-edge read of a written address sees the old word.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  assign xfer     = valid_q & out_ready;
  assign start_go = start & ~stop;

  // Clamp compared one bit wider so non-power-of-two depths clamp correctly.
  always_comb begin
    len_cap = seq_len;
    if ((ADDR_W + 1)'(seq_len) > (ADDR_W + 1)'(DEPTH - 1)) begin
      len_cap = ADDR_W'(DEPTH - 1);
    end
  end

  // A pass ends on this beat and the requested pass count is then satisfied.
  always_comb begin
    final_beat = 1'b0;
    if (last_q) begin
      if (mode_q == M_ONESHOT) begin
        final_beat = 1'b1;
      end else if ((passes_q != '0) && (pass_q == passes_q - REP_W'(1))) begin
        final_beat = 1'b1;
      end
    end
  end

  // Successor index/direction; len=0 ping-pong parks at index 0 going up.
  always_comb begin
    idx_step = idx_q;
    up_step  = up_q;
    if (mode_q == M_PINGPONG) begin
      if (up_q) begin
        if (idx_q == len_q) begin
          if (len_q != '0) begin
            idx_step = idx_q - ADDR_W'(1);
            up_step  = 1'b0;
          end
        end else begin
          idx_step = idx_q + ADDR_W'(1);
        end
      end else begin
        if (idx_q == '0) begin
          if (len_q != '0) begin
            idx_step = ADDR_W'(1);
            up_step  = 1'b1;
          end
        end else begin
          idx_step = idx_q - ADDR_W'(1);
        end
      end
    end else begin
      idx_step = (idx_q == len_q) ? '0 : idx_q + ADDR_W'(1);
    end
    if ((mode_q == M_PINGPONG) && !up_step) begin
      last_step = (idx_step == '0);
    end else begin
      last_step = (idx_step == len_q);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer && (stop || final_beat)) begin
          state_d = S_IDLE;
        end else if (stop) begin
          state_d = S_STOPPING;
        end
      end
      S_STOPPING: begin
        if (xfer) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and playback context.
  always_comb begin
    idx_d    = idx_q;
    up_d     = up_q;
    pass_d   = pass_q;
    len_d    = len_q;
    mode_d   = mode_q;
    passes_d = passes_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          len_d    = len_cap;
          mode_d   = (mode == 2'b11) ? M_ONESHOT : mode;
          passes_d = passes;
          idx_d    = '0;
          up_d     = 1'b1;
          pass_d   = '0;
          valid_d  = 1'b1;
          data_d   = mem[0];
          last_d   = (len_cap == '0);
          busy_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (stop || final_beat) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_step;
            up_d   = up_step;
            data_d = mem[idx_step];
            last_d = last_step;
            if (last_q && (pass_q != '1)) begin
              pass_d = pass_q + REP_W'(1);
            end
          end
        end
      end
      S_STOPPING: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      up_q     <= 1'b1;
      pass_q   <= '0;
      len_q    <= '0;
      mode_q   <= M_ONESHOT;
      passes_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      up_q     <= up_d;
      pass_q   <= pass_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      passes_q <= passes_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
